// File: rtl/output_unloader_if.sv
// Byte-stream sink bundle for output_unloader: the sampled stream byte in, reassembled frame out.
interface output_unloader_if #(parameter int W = 32);
  logic [7:0]   in_byte;
  logic         busy;
  logic [W-1:0] wordA;
  logic [W-1:0] wordB;
  logic [2:0]   mode_out;
  logic         frame_valid;
  logic         frame_err;
  logic [7:0]   err_cnt;

  modport master (output in_byte,
                  input  busy, wordA, wordB, mode_out, frame_valid, frame_err, err_cnt);
  modport slave  (input  in_byte,
                  output busy, wordA, wordB, mode_out, frame_valid, frame_err, err_cnt);
endinterface

// File: rtl/output_unloader.sv
// Reassembles {mode, A, B} frames from a nibble-serial byte stream and flags framing aborts.
// Optional saturating abort counter on err_cnt when OUTPUT_UNLOADER_ERRCNT_EN is defined.
module output_unloader #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output_unloader_if.slave  bus
);
  localparam int NIB = W / 4;
  localparam int CW  = $clog2(NIB) + 1;
  localparam logic [CW-1:0] NIB_C = CW'(NIB);

  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [W-1:0]    sh_a, sh_b;
  logic [W-1:0]    word_a, word_b;
  logic [2:0]      mode_cap, mode_q;
  logic            valid_q, err_q;
  logic            start, shift_a, shift_b, abort, done;

  logic [2:0] mode_in;
  logic       rdy;
  logic [3:0] nib;
  assign mode_in = bus.in_byte[7:5];
  assign rdy     = bus.in_byte[4];
  assign nib     = bus.in_byte[3:0];
  assign cnt_inc = cnt + CW'(1);

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] sh, input logic [3:0] n);
    return (sh << 4) | W'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    shift_a   = 1'b0;
    shift_b   = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (rdy) begin
          start   = 1'b1;
          shift_a = 1'b1;
          if (NIB_C == CW'(1)) begin
            state_nxt = RECV_B;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RECV_A;
            cnt_nxt   = CW'(1);
          end
        end
      end
      RECV_A, RECV_B: begin
        // A gap or a mode change mid-frame drops the frame; the offending byte is not reused.
        if (!rdy || (mode_in != mode_cap)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (state == RECV_A) begin
          shift_a = 1'b1;
          if (cnt_inc == NIB_C) begin
            state_nxt = RECV_B;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          shift_b = 1'b1;
          if (cnt_inc == NIB_C) begin
            done      = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      mode_cap <= '0;
      word_a   <= '0;
      word_b   <= '0;
      mode_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= done;
      err_q   <= abort;
      if (start)   mode_cap <= mode_in;
      if (shift_a) sh_a     <= shift_in(sh_a, nib);
      if (shift_b) sh_b     <= shift_in(sh_b, nib);
      if (done) begin
        word_a <= sh_a;
        word_b <= shift_in(sh_b, nib);
        mode_q <= mode_cap;
      end
    end
  end

  assign bus.wordA       = word_a;
  assign bus.wordB       = word_b;
  assign bus.mode_out    = mode_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;

`ifdef OUTPUT_UNLOADER_ERRCNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= 8'h00;
    else if (abort && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_output_unloader.sv
// Self-checking bench for output_unloader: directed frames plus randomized streams vs a frame-level model.
module tb_output_unloader;
  localparam int W     = 32;
  localparam int FRAME = 2 * (W / 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  output_unloader_if #(.W(W)) bus();
  output_unloader #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Frame-level reference: count bytes of the current frame and accumulate nibbles arithmetically.
  int          m_n;
  logic [63:0] m_acc;
  logic [2:0]  m_mode;
  logic [31:0] e_wa, e_wb;
  logic [2:0]  e_mode;
  logic        e_fv, e_fe;
  int          e_err;

  function automatic void model_reset();
    m_n = 0; m_acc = '0; m_mode = '0;
    e_wa = '0; e_wb = '0; e_mode = '0; e_fv = 1'b0; e_fe = 1'b0; e_err = 0;
  endfunction

  function automatic void model_step(input logic [7:0] b);
    e_fv = 1'b0;
    e_fe = 1'b0;
    if (m_n == 0) begin
      if (b[4]) begin
        m_n = 1; m_mode = b[7:5]; m_acc = 64'(b[3:0]);
      end
    end else if (!b[4] || b[7:5] != m_mode) begin
      e_fe = 1'b1;
      m_n  = 0;
      if (e_err < 255) e_err = e_err + 1;
    end else begin
      m_acc = m_acc * 16 + 64'(b[3:0]);
      m_n   = m_n + 1;
      if (m_n == FRAME) begin
        e_fv = 1'b1; e_wa = m_acc[63:32]; e_wb = m_acc[31:0]; e_mode = m_mode; m_n = 0;
      end
    end
  endfunction

  function automatic logic [78:0] observed();
    return {bus.busy, bus.frame_valid, bus.frame_err, bus.err_cnt, bus.mode_out, bus.wordB, bus.wordA};
  endfunction

  function automatic logic [78:0] expected();
    logic [7:0] ec;
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
    ec = 8'(e_err);
`else
    ec = 8'h00;
`endif
    return {(m_n != 0), e_fv, e_fe, ec, e_mode, e_wb, e_wa};
  endfunction

  function automatic logic [7:0] fbyte(input logic [2:0] m, input logic [63:0] v, input int k);
    logic [3:0] n;
    n = v[63 - 4*k -: 4];
    return {m, 1'b1, n};
  endfunction

  task automatic drive(input logic [7:0] b);
    bus.in_byte = b;
    @(posedge clk);
    model_step(b);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_byte = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (observed() !== 79'd0) begin
      bad++; $display("FAIL reset_state got %h want %h", observed(), 79'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    logic [63:0] v = {32'hDEADBEEF, 32'h12345678};
    int fv_seen = 0;
    for (int k = 0; k < FRAME; k++) begin
      drive(fbyte(3'b101, v, k));
      if (bus.frame_valid) fv_seen++;
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL good_frame byte %0d got %h want %h", k, observed(), expected());
      end
    end
    drive(8'h00);
    if (bus.frame_valid) fv_seen++;
    total++;
    if (fv_seen != 1 || bus.wordA !== 32'hDEADBEEF || bus.wordB !== 32'h12345678 || bus.mode_out !== 3'd5) begin
      bad++;
      $display("FAIL good_frame_result got fv=%0d A=%h B=%h m=%0d want fv=1 A=deadbeef B=12345678 m=5",
               fv_seen, bus.wordA, bus.wordB, bus.mode_out);
    end
  endtask

  task automatic test_gap_abort();
    logic [63:0] v = {32'hCAFEF00D, 32'h0BADC0DE};
    int fe_seen = 0;
    for (int k = 0; k < 6; k++) begin
      drive(k < 5 ? fbyte(3'b101, v, k) : 8'h00);
      if (bus.frame_err) fe_seen++;
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL gap_abort byte %0d got %h want %h", k, observed(), expected());
      end
    end
    total++;
    if (fe_seen != 1 || bus.frame_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.wordA !== 32'hDEADBEEF || bus.wordB !== 32'h12345678) begin
      bad++;
      $display("FAIL gap_abort_hold got fe=%0d fv=%b busy=%b A=%h B=%h want fe=1 fv=0 busy=0 A=deadbeef B=12345678",
               fe_seen, bus.frame_valid, bus.busy, bus.wordA, bus.wordB);
    end
  endtask

  task automatic test_mode_mismatch();
    logic [63:0] v1 = {32'h11112222, 32'h33334444};
    logic [63:0] v2 = {32'h00000000, 32'hFFFFFFFF};
    logic [7:0]  b;
    int fe_seen = 0;
    for (int k = 0; k < 10; k++) begin
      b = fbyte(3'b010, v1, k);
      if (k == 9) b[7:5] = 3'b011;
      drive(b);
      if (bus.frame_err) fe_seen++;
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL mode_mismatch byte %0d got %h want %h", k, observed(), expected());
      end
    end
    for (int k = 0; k < FRAME; k++) begin
      drive(fbyte(3'b010, v2, k));
      if (bus.frame_err) fe_seen++;
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL mode_recover byte %0d got %h want %h", k, observed(), expected());
      end
    end
    total++;
    if (fe_seen != 1 || bus.frame_valid !== 1'b1 || bus.wordA !== 32'h0 ||
        bus.wordB !== 32'hFFFFFFFF || bus.mode_out !== 3'd2) begin
      bad++;
      $display("FAIL mode_recover_result got fe=%0d fv=%b A=%h B=%h m=%0d want fe=1 fv=1 A=0 B=ffffffff m=2",
               fe_seen, bus.frame_valid, bus.wordA, bus.wordB, bus.mode_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    int fv_cyc[$];
    int ok = 1;
    for (int f = 0; f < 3; f++) begin
      v = {32'(2*f + 1), 32'(2*f + 2)};
      for (int k = 0; k < FRAME; k++) begin
        drive(f < 2 ? fbyte(3'b001, v, k) : 8'h00);
        if (bus.frame_valid) begin
          fv_cyc.push_back(cyc);
          if (bus.wordA !== 32'(2*fv_cyc.size() - 1) || bus.wordB !== 32'(2*fv_cyc.size())) ok = 0;
        end
        total++;
        if (observed() !== expected()) begin
          bad++; $display("FAIL back_to_back f%0d byte %0d got %h want %h", f, k, observed(), expected());
        end
      end
    end
    total++;
    if (fv_cyc.size() != 2 || ok == 0 || (fv_cyc[1] - fv_cyc[0]) != FRAME) begin
      bad++;
      $display("FAIL back_to_back_spacing got pulses=%0d words_ok=%0d gap=%0d want pulses=2 words_ok=1 gap=%0d",
               fv_cyc.size(), ok, fv_cyc.size() == 2 ? fv_cyc[1] - fv_cyc[0] : -1, FRAME);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v = {32'hA5A55A5A, 32'h01234567};
    for (int k = 0; k < 8; k++) drive(fbyte(3'b110, v, k));
    rst = 1'b1;
    bus.in_byte = fbyte(3'b110, v, 8);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    total++;
    if (observed() !== 79'd0) begin
      bad++; $display("FAIL reset_mid got %h want %h", observed(), 79'd0);
    end
    for (int k = 0; k < FRAME; k++) begin
      drive(fbyte(3'b110, v, k));
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL reset_mid_frame byte %0d got %h want %h", k, observed(), expected());
      end
    end
    total++;
    if (bus.wordA !== 32'hA5A55A5A || bus.wordB !== 32'h01234567 || bus.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_result got A=%h B=%h fv=%b want A=a5a55a5a B=01234567 fv=1",
               bus.wordA, bus.wordB, bus.frame_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] v;
    logic [2:0]  m;
    logic [7:0]  b;
    int kind, pos;
    for (int f = 0; f < 40; f++) begin
      m    = 3'($urandom);
      v    = {32'($urandom), 32'($urandom)};
      kind = $urandom_range(0, 3);
      pos  = $urandom_range(1, FRAME - 1);
      repeat ($urandom_range(0, 2)) begin
        drive({3'($urandom), 1'b0, 4'($urandom)});
        total++;
        if (observed() !== expected()) begin
          bad++; $display("FAIL random_idle f%0d got %h want %h", f, observed(), expected());
        end
      end
      for (int k = 0; k < FRAME; k++) begin
        b = fbyte(m, v, k);
        if (k == pos && kind == 1) b[4] = 1'b0;
        if (k == pos && kind == 2) b[7:5] = m ^ 3'($urandom_range(1, 7));
        drive(b);
        total++;
        if (observed() !== expected()) begin
          bad++; $display("FAIL random f%0d kind %0d byte %0d got %h want %h", f, kind, k, observed(), expected());
        end
      end
    end
    drive(8'h00);
    drive(8'h00);
  endtask

  task automatic test_err_saturation();
    logic [7:0] want;
    for (int i = 0; i < 300; i++) begin
      drive({3'b100, 1'b1, 4'($urandom)});
      drive(8'h00);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL err_sat abort %0d got %h want %h", i, observed(), expected());
      end
    end
`ifdef OUTPUT_UNLOADER_ERRCNT_EN
    want = 8'd255;
`else
    want = 8'd0;
`endif
    total++;
    if (bus.err_cnt !== want) begin
      bad++; $display("FAIL err_cnt_final got %0d want %0d", bus.err_cnt, want);
    end
  endtask

  initial begin
    bus.in_byte = 8'hFF;
    model_reset();
    test_reset();
    test_good_frame();
    test_gap_abort();
    test_mode_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_err_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/output_unloader.md
Name: output_unloader

Overview:
- Receive-side counterpart to the nibble-serial output stage.
- Samples the 8-bit byte stream {mode[2:0], rdy, nibble[3:0]}, one byte per clock.
- Reassembles two W-bit words (A then B, most-significant nibble first) and the 3-bit mode.
- Flags framing errors and presents each completed frame with a one-cycle valid pulse.

Parameters:
- W, 32, word width in bits; must be a multiple of 4. NIB = W/4 nibbles per word.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_byte  in  8  stream byte: [7:5] mode, [4] rdy marker, [3:0] nibble
- busy  out  1  high while a frame is being received (state != IDLE)
- wordA  out  W  last good word A
- wordB  out  W  last good word B
- mode_out  out  3  mode of last good frame
- frame_valid  out  1  one-cycle pulse; wordA/wordB/mode_out updated this cycle
- frame_err  out  1  one-cycle pulse on frame abort
- err_cnt  out  8  error count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge) clears everything:
  - state=IDLE, nibble counter=0, shift registers=0.
  - wordA=0, wordB=0, mode_out=0, frame_valid=0, frame_err=0, err_cnt=0.
  - Reset mid-frame discards the partial frame; no error pulse.
- States are IDLE, RECV_A, RECV_B. Counter width is clog2(NIB)+1 bits.
- IDLE:
  - in_byte[4]=0: stay in IDLE.
  - in_byte[4]=1: capture mode=in_byte[7:5], shift in_byte[3:0] into shA LSBs (shA <= {shA[W-5:0], nib}), cnt=1, go to RECV_A.
- RECV_A, per sampled byte:
  - in_byte[4]=0 (gap): abort. frame_err=1 next cycle, go to IDLE. The byte is not treated as a frame start.
  - in_byte[4]=1 and in_byte[7:5] != captured mode: abort the same way. The offending byte is discarded.
  - Otherwise: shift the nibble into shA, cnt+1. When cnt reaches NIB: cnt=0, go to RECV_B.
- RECV_B:
  - Gap and mode-mismatch checks are identical to RECV_A; the nibble shifts into shB.
  - On the NIB-th B nibble, at the next edge: wordA=shA, wordB={shB[W-5:0], nib}, mode_out=captured mode, frame_valid=1, state=IDLE.
- Latency: frame_valid is high in the cycle after the 2*NIB-th byte is sampled.
- Back-to-back frames: a byte with rdy=1 sampled in the same cycle frame_valid is high starts a new frame. No idle byte is required between frames.
- Outputs are held between frames. wordA/wordB/mode_out change only on frame_valid; an aborted frame leaves them unchanged.
- frame_valid and frame_err are never high together. Each is a registered single-cycle pulse.
- busy is combinational from state. It is 1 from the cycle after the first rdy byte until the cycle frame_valid or frame_err is high, where busy=0.

Optional Feature:
- Macro: OUTPUT_UNLOADER_ERRCNT_EN
- Defined: err_cnt is an 8-bit saturating counter.
  - Increments by 1 in the same edge that raises frame_err.
  - Sticks at 255.
  - Cleared only by rst.
- Undefined: err_cnt is tied to 8'h00 and no counter logic is generated. Port list is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_byte=8'hFF. Outputs all 0, busy=0, no frame_valid or frame_err.
- Good frame: mode=3'b101, A=32'hDEADBEEF, B=32'h12345678, driven as 16 consecutive bytes 8'hBD, 8'hBE, 8'hBA, ..., 8'hB8. Required response:
  - frame_valid pulses exactly one cycle, one cycle after byte 16.
  - wordA=DEADBEEF, wordB=12345678, mode_out=5.
  - busy high for cycles 2..16.
- Gap abort: after a good frame, send 5 valid bytes then 8'h00. frame_err pulses once, no frame_valid, wordA/wordB still DEADBEEF/12345678, busy=0.
- Mode mismatch: mode=3'b010 frame with byte 10 carrying mode 3'b011. frame_err pulses; a following clean 16-byte mode-2 frame (A=0, B=FFFFFFFF) completes correctly.
- Back-to-back: two frames (A=1/B=2, then A=3/B=4) with no idle byte between. frame_valid pulses exactly 16 cycles apart, with the correct word values each time.
- Reset mid-frame and counter:
  - Assert rst after byte 8 of a frame: busy=0 and outputs=0 next cycle, no frame_err; the next full frame is received correctly.
  - With OUTPUT_UNLOADER_ERRCNT_EN defined, 300 gap aborts give err_cnt=255.
